// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel FSM states, CTRL field
// positions, MODE encodings and the per-channel register offsets.
package timer_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } ch_state_t;

   // MODE 00 is one-shot; 1x is reserved and behaves as one-shot.
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   // CTRL layout: [0] EN, [2:1] MODE, [3] IM, [7:4] PS
   localparam int unsigned CTRL_W    = 8;
   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_MODE = 1;
   localparam int unsigned CTRL_IM   = 3;
   localparam int unsigned CTRL_PS   = 4;

   // Word offsets within one channel's 4-word window
   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_PRESET = 1;
   localparam int unsigned REG_COUNT  = 2;

   // Word offset of register r belonging to channel ch
   function automatic int unsigned reg_off(input int unsigned ch, input int unsigned r);
      return 4 * ch + r;
   endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: CTRL/PRESET registers, prescaler, down-counter and the
// IDLE/LOAD/CNT/INT sequencer. expire pulses for the single cycle in which
// the channel leaves CNT on expiry, so the pending flag lands on that edge.
module timer_bank_channel
   import timer_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ctrl_we,
   input  logic [CTRL_W-1:0] ctrl_din,
   input  logic              preset_we,
   input  logic [WIDTH-1:0]  preset_din,
   output logic [CTRL_W-1:0] ctrl,
   output logic [WIDTH-1:0]  preset,
   output logic [WIDTH-1:0]  count,
   output logic              expire
);

   ch_state_t  state;
   logic [3:0] pscnt;
   logic       en;
   logic       tick;

   assign en     = ctrl[CTRL_EN];
   assign tick   = (pscnt == ctrl[CTRL_PS +: 4]);
   assign expire = (state == ST_CNT) && en && tick && (count <= WIDTH'(1));

   // Register writes plus the channel sequencer; a CTRL write in the INT cycle overrides the EN auto-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         ctrl   <= '0;
         preset <= '0;
         count  <= '0;
         pscnt  <= '0;
      end else begin
         if (preset_we) preset <= preset_din;
         if (ctrl_we)   ctrl   <= ctrl_din;
         case (state)
            ST_IDLE: begin
               if (en) state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               pscnt <= '0;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!en) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  pscnt <= '0;
                  if (count > WIDTH'(1)) begin
                     count <= count - 1'b1;
                  end else begin
                     count <= '0;
                     state <= ST_INT;
                  end
               end else begin
                  pscnt <= pscnt + 1'b1;
               end
            end
            ST_INT: begin
               if (ctrl[CTRL_MODE +: 2] == MODE_RELOAD) begin
                  state <= ST_LOAD;
               end else begin
                  if (!ctrl_we) ctrl[CTRL_EN] <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer. Decodes the word offset inside the
// Bridge slot, muxes read data, keeps the sticky pending flags and drives
// the merged, registered IRQ.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned OFF_W  = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam int unsigned STATUS_OFF = 4 * NUM_CH;

   logic [OFF_W-1:0]  off;
   logic [CTRL_W-1:0] ctrl   [NUM_CH];
   logic [WIDTH-1:0]  preset [NUM_CH];
   logic [WIDTH-1:0]  count  [NUM_CH];
   logic [NUM_CH-1:0] expire;
   logic [NUM_CH-1:0] ctrl_we;
   logic [NUM_CH-1:0] preset_we;
   logic [NUM_CH-1:0] im_next;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] pending_next;
   logic [NUM_CH-1:0] status_clr;
   logic              status_we;
   logic              unused_bits;

   assign off         = Addr[OFF_W+1:2];
   assign unused_bits = ^{Addr[31:OFF_W+2], Din};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_bank_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .ctrl_we    (ctrl_we[g]),
         .ctrl_din   (Din[CTRL_W-1:0]),
         .preset_we  (preset_we[g]),
         .preset_din (Din[WIDTH-1:0]),
         .ctrl       (ctrl[g]),
         .preset     (preset[g]),
         .count      (count[g]),
         .expire     (expire[g])
      );
   end

   // Write decode; IRQ is registered from next-state pending/IM so it lands on the same edge as the flag
   always_comb begin
      ctrl_we   = '0;
      preset_we = '0;
      im_next   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         ctrl_we[c]   = WE && (off == OFF_W'(reg_off(c, REG_CTRL)));
         preset_we[c] = WE && (off == OFF_W'(reg_off(c, REG_PRESET)));
         im_next[c]   = ctrl_we[c] ? Din[CTRL_IM] : ctrl[c][CTRL_IM];
      end
      status_we    = WE && (off == OFF_W'(STATUS_OFF));
      status_clr   = status_we ? Din[NUM_CH-1:0] : '0;
      pending_next = (pending & ~status_clr) | expire;
   end

   // Combinational read mux; reserved and unmapped offsets read zero
   always_comb begin
      Dout = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (off == OFF_W'(reg_off(c, REG_CTRL)))   Dout = 32'(ctrl[c]);
         if (off == OFF_W'(reg_off(c, REG_PRESET))) Dout = 32'(preset[c]);
         if (off == OFF_W'(reg_off(c, REG_COUNT)))  Dout = 32'(count[c]);
      end
      if (off == OFF_W'(STATUS_OFF)) Dout = 32'(pending);
   end

   // Sticky pending flags (expiry beats a same-cycle clear) and the merged interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         IRQ     <= 1'b0;
      end else begin
         pending <= pending_next;
         IRQ     <= |(pending_next & im_next);
      end
   end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised scoreboard bench for timer_bank. The reference model predicts
// each channel's behaviour from the expiry schedule (enable edge, preset,
// prescale, period) with plain arithmetic; the monitor compares on negedge.
module tb_timer_bank;

   localparam int unsigned NCH    = 2;
   localparam int unsigned STATUS = 4 * NCH;
   localparam longint      NEVER  = 64'h7fff_ffff_ffff;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic [31:2] Addr8 = '0;
   logic        WE8 = 1'b0;
   logic [31:0] Din8 = '0;
   logic [31:0] Dout8;
   logic        IRQ8;

   timer_bank #(.NUM_CH(NCH), .WIDTH(32), .OFF_W(6)) dut (
      .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
   );

   timer_bank #(.NUM_CH(1), .WIDTH(8), .OFF_W(3)) dut8 (
      .clk(clk), .reset(reset), .Addr(Addr8), .WE(WE8), .Din(Din8), .Dout(Dout8), .IRQ(IRQ8)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          w8;
      int unsigned off;
      logic [31:0] exp;
   } rd_t;

   rd_t rdq[$];
   bit  irqq[$];
   bit  irq8q[$];
   bit  rd_valid = 1'b0;
   int  checks = 0;
   int  failures = 0;
   longint cyc = 0;

   // reference model state
   logic [7:0]     m_ctrl   [NCH];
   logic [31:0]    m_preset [NCH];
   logic [NCH-1:0] m_pend;
   int             act = -1;
   longint         n_en = 0;
   longint         stop_e = NEVER;
   longint         T = 1;
   int unsigned    P = 0;
   int unsigned    PS = 0;
   bit             reload = 1'b0;
   logic [31:0]    pre_cnt = '0;
   longint         e8 = NEVER;

   // write currently on the bus, applied to the model at its landing edge
   bit             w_pend = 1'b0;
   bit             w_is8 = 1'b0;
   int unsigned    w_off = 0;
   logic [31:0]    w_data = '0;

   function automatic void set_period();
      T = longint'((P == 0) ? 1 : P) * longint'(PS + 1);
   endfunction

   function automatic bit is_exp(input longint k);
      longint e0;
      e0 = n_en + 2 + T;
      if (act < 0 || k < e0 || k > stop_e) return 1'b0;
      if (!reload) return k == e0;
      return ((k - e0) % (T + 2)) == 0;
   endfunction

   function automatic logic [31:0] count_at(input longint k);
      longint kk, ofs;
      kk = (k > stop_e) ? stop_e : k;
      if (kk < n_en + 2) return pre_cnt;
      if (!reload && (kk - n_en - 2) >= T) return '0;
      ofs = (kk - n_en - 2) % (T + 2);
      if (ofs >= T) return '0;
      return 32'(longint'(P) - ofs / longint'(PS + 1));
   endfunction

   function automatic bit en_at(input longint k);
      if (stop_e != NEVER) return m_ctrl[act][0];
      if (reload) return 1'b1;
      return k <= n_en + 2 + T;
   endfunction

   function automatic logic [31:0] exp_read(input int unsigned off);
      int c;
      if (off < 4 * NCH) begin
         c = int'(off / 4);
         case (off % 4)
            0: return (c == act) ? {24'b0, m_ctrl[c][7:1], en_at(cyc)} : {24'b0, m_ctrl[c]};
            1: return m_preset[c];
            2: return (c == act) ? count_at(cyc) : '0;
            default: return '0;
         endcase
      end
      if (off == STATUS) return 32'(m_pend);
      return '0;
   endfunction

   function automatic logic [NCH-1:0] im_bits();
      logic [NCH-1:0] r;
      for (int i = 0; i < int'(NCH); i++) r[i] = m_ctrl[i][3];
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < int'(NCH); i++) begin
         m_ctrl[i]   = '0;
         m_preset[i] = '0;
      end
      m_pend  = '0;
      act     = -1;
      stop_e  = NEVER;
      pre_cnt = '0;
      e8      = NEVER;
   endfunction

   // Advance one clock edge and update the model for it
   task automatic step();
      int wc;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         model_reset();
      end else begin
         if (w_pend && !w_is8) begin
            if (w_off < 4 * NCH) begin
               wc = int'(w_off / 4);
               if (w_off % 4 == 0) m_ctrl[wc] = w_data[7:0];
               if (w_off % 4 == 1) m_preset[wc] = w_data;
            end else if (w_off == STATUS) begin
               m_pend = m_pend & ~w_data[NCH-1:0];
            end
         end
         if (act >= 0 && is_exp(cyc)) m_pend[act] = 1'b1;
      end
      irqq.push_back(|(m_pend & im_bits()));
      irq8q.push_back(cyc >= e8);
      WE       = 1'b0;
      WE8      = 1'b0;
      w_pend   = 1'b0;
      rd_valid = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic rd(input int unsigned off);
      Addr      = 30'($urandom);
      Addr[7:2] = 6'(off);
      WE        = 1'b0;
      rdq.push_back('{1'b0, off, exp_read(off)});
      rd_valid  = 1'b1;
      step();
   endtask

   task automatic wr(input int unsigned off, input logic [31:0] data);
      Addr      = 30'($urandom);
      Addr[7:2] = 6'(off);
      WE        = 1'b1;
      Din       = data;
      w_pend    = 1'b1;
      w_is8     = 1'b0;
      w_off     = off;
      w_data    = data;
      step();
   endtask

   task automatic rd8(input int unsigned off, input logic [31:0] exp);
      Addr8      = 30'($urandom);
      Addr8[4:2] = 3'(off);
      WE8        = 1'b0;
      rdq.push_back('{1'b1, off, exp});
      rd_valid   = 1'b1;
      step();
   endtask

   task automatic wr8(input int unsigned off, input logic [31:0] data);
      Addr8      = 30'($urandom);
      Addr8[4:2] = 3'(off);
      WE8        = 1'b1;
      Din8       = data;
      w_pend     = 1'b1;
      w_is8      = 1'b1;
      step();
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
   endtask

   // One channel run: program, enable, then random reads/writes/collisions, ending in a reset
   task automatic scenario(input int unsigned c, input int unsigned p, input int unsigned ps,
                           input int unsigned mode, input int unsigned im);
      logic [7:0]  cw;
      longint      e;
      int unsigned runlen, o;
      P = p; PS = ps; reload = (mode == 1); set_period();
      wr(c * 4 + 1, 32'(p));
      rd(c * 4 + 1);
      act = int'(c); n_en = cyc + 1; stop_e = NEVER; pre_cnt = '0;
      cw = {4'(ps), 1'(im), 2'(mode), 1'b1};
      wr(c * 4, 32'(cw));
      e = n_en + 2 + T;
      runlen = reload ? int'(3 * (T + 2) + 4) : int'(T + 8);
      for (int unsigned i = 0; i < runlen; i++) begin
         if (reload && is_exp(cyc + 1) && $urandom_range(1, 0) == 1) begin
            wr(STATUS, 32'(1) << c);
         end else begin
            case ($urandom_range(9, 0))
               0: wr(STATUS, $urandom);
               1: begin
                  cw = m_ctrl[c] ^ 8'h08;
                  cw[0] = reload ? 1'b1 : (cyc + 1 <= e);
                  wr(c * 4, 32'(cw));
               end
               2: begin
                  case ($urandom_range(2, 0))
                     0: o = c * 4 + 2;
                     1: o = c * 4 + 3;
                     default: o = $urandom_range(63, STATUS + 1);
                  endcase
                  wr(o, $urandom);
               end
               3: rd(STATUS);
               4: rd(c * 4);
               5: rd($urandom_range(63, 0));
               default: rd(c * 4 + 2);
            endcase
         end
      end
      reset_pulse();
      rd(c * 4); rd(c * 4 + 1); rd(c * 4 + 2); rd(STATUS);
   endtask

   // EN cleared mid-count holds COUNT; re-enable reloads from the PRESET written during the count
   task automatic stop_restart();
      logic [31:0] frozen;
      P = $urandom_range(25, 15); PS = 0; reload = 1'b0; set_period();
      wr(1, 32'(P));
      act = 0; n_en = cyc + 1; stop_e = NEVER; pre_cnt = '0;
      wr(0, 32'h09);
      repeat (4) rd(2);
      wr(1, 32'd3);
      repeat ($urandom_range(5, 0)) rd(2);
      stop_e = cyc + 1;
      wr(0, 32'h08);
      repeat (3) begin
         rd(2); rd(STATUS); rd(0);
      end
      frozen = count_at(stop_e);
      pre_cnt = frozen;
      P = m_preset[0]; set_period();
      n_en = cyc + 1; stop_e = NEVER;
      wr(0, 32'h09);
      for (int unsigned i = 0; i < P + 6; i++) rd((i % 2 == 1) ? STATUS : 2);
      wr(STATUS, 32'h1);
      rd(STATUS); rd(0);
      reset_pulse();
      rd(0); rd(1); rd(2); rd(STATUS);
   endtask

   // WIDTH=8 instance: truncated writes, short one-shot run, decode holes
   task automatic narrow_test();
      longint n8;
      wr8(1, 32'h1FF);
      rd8(1, 32'hFF);
      wr8(1, 32'hAB02);
      rd8(1, 32'h02);
      n8 = cyc + 1;
      e8 = n8 + 4;
      wr8(0, 32'h09);
      for (int i = 0; i < 7; i++) begin
         longint k;
         logic [31:0] ex;
         k = cyc;
         if (k < n8 + 2 || k >= e8) ex = '0;
         else ex = 32'(2 - (k - n8 - 2));
         rd8(2, ex);
      end
      rd8(4, 32'h1);
      rd8(3, '0); rd8(5, '0); rd8(6, '0); rd8(7, '0);
   endtask

   // Monitor: checks read data whenever a read is presented, and IRQ every cycle
   always @(negedge clk) begin
      rd_t e;
      logic [31:0] got;
      bit ei;
      if (rd_valid) begin
         checks++;
         if (rdq.size() == 0) begin
            failures++;
            $display("FAIL rd_queue_empty got=none required=entry");
         end else begin
            e = rdq.pop_front();
            got = e.w8 ? Dout8 : Dout;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL rd w8=%0d off=%0d cyc=%0d got=%h required=%h", e.w8, e.off, cyc, got, e.exp);
            end
         end
      end
      if (irqq.size() > 0) begin
         ei = irqq.pop_front();
         checks++;
         if (IRQ !== ei) begin
            failures++;
            $display("FAIL irq cyc=%0d got=%b required=%b", cyc, IRQ, ei);
         end
      end
      if (irq8q.size() > 0) begin
         ei = irq8q.pop_front();
         checks++;
         if (IRQ8 !== ei) begin
            failures++;
            $display("FAIL irq8 cyc=%0d got=%b required=%b", cyc, IRQ8, ei);
         end
      end
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog got=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset_pulse();
      reset_pulse();
      for (int unsigned o = 0; o < 12; o++) rd(o);
      scenario(0, 5, 0, 0, 1);
      scenario(1, 3, 0, 1, 1);
      scenario(0, 2, 3, 0, 1);
      scenario(1, 4, 0, 1, 0);
      scenario(0, 0, 0, 1, 1);
      stop_restart();
      for (int i = 0; i < 10; i++) begin
         scenario($urandom_range(NCH - 1, 0), $urandom_range(12, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(1, 0));
      end
      narrow_test();
      reset_pulse();
      rd(STATUS);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
